// File: rtl/muldiv_if.sv
// Decode <-> muldiv_unit bundle: request strobes, forwarded operands, HI/LO readback and stall.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             mult, multu, div, divu, mthi, mtlo;
    logic             mfhi, mflo, issue;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, done, stall;

    modport master (
        output mult, multu, div, divu, mthi, mtlo, mfhi, mflo, issue, a, b,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  mult, multu, div, divu, mthi, mtlo, mfhi, mflo, issue, a, b,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit owning HI/LO; the divider is built only when
// MULDIV_DIV_EN is defined, otherwise div/divu are accepted as no-ops.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [2:0] {
        OP_NONE, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO
    } op_t;

    state_t             state, state_nxt;
    op_t                req;
    logic [4:0]         cnt;
    logic [2*WIDTH-1:0] acc, acc_step;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               a_neg, b_neg, signed_op;
    logic               neg_lo;
    logic               done_q;
    logic               any_req, accept, start;
`ifdef MULDIV_DIV_EN
    logic               is_div, neg_hi;
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req = OP_NONE;
        if (bus.issue) begin
            if      (bus.mult)  req = OP_MULT;
            else if (bus.multu) req = OP_MULTU;
            else if (bus.div)   req = OP_DIV;
            else if (bus.divu)  req = OP_DIVU;
            else if (bus.mthi)  req = OP_MTHI;
            else if (bus.mtlo)  req = OP_MTLO;
        end
    end

    assign any_req   = bus.mult | bus.multu | bus.div | bus.divu | bus.mthi | bus.mtlo;
    assign bus.busy  = (state == RUN);
    assign bus.stall = !((state == RUN) && ((bus.issue && any_req) || bus.mfhi || bus.mflo));
    assign accept    = (state == IDLE) && bus.stall && (req != OP_NONE);
`ifdef MULDIV_DIV_EN
    assign start = accept && (req inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});
`else
    assign start = accept && (req inside {OP_MULT, OP_MULTU});
`endif

    // Signed ops run on magnitudes; signs are reapplied at completion.
    assign signed_op = (req == OP_MULT) || (req == OP_DIV);
    assign a_neg     = signed_op & bus.a[WIDTH-1];
    assign b_neg     = signed_op & bus.b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        logic [WIDTH:0]   sum;
`ifdef MULDIV_DIV_EN
        logic [WIDTH:0]   shifted;
        logic [WIDTH+1:0] diff;
`endif
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        acc_step = {sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, opb};
        if (is_div) begin
            if (!diff[WIDTH+1])
                acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
`endif
    end

    always_comb begin
        logic [2*WIDTH-1:0] prod;
        prod   = neg_lo ? -acc_step : acc_step;
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
        if (is_div) begin
            res_lo = neg_lo ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
            res_hi = neg_hi ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: the datapath registers are few and all reset, so a mid-run reset leaves no stale partial result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opb    <= '0;
            neg_lo <= 1'b0;
`ifdef MULDIV_DIV_EN
            is_div <= 1'b0;
            neg_hi <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (start) begin
                cnt    <= '0;
                acc    <= {{WIDTH{1'b0}}, a_mag};
                opb    <= b_mag;
                // Divide by zero keeps the all-ones quotient unsigned.
                neg_lo <= (a_neg ^ b_neg) & (|bus.b);
`ifdef MULDIV_DIV_EN
                is_div <= (req == OP_DIV) || (req == OP_DIVU);
                neg_hi <= a_neg;
`endif
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
            end
            if (accept && req == OP_MTHI) hi_q <= bus.a;
            if (accept && req == OP_MTLO) lo_q <= bus.a;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; div expectations follow MULDIV_DIV_EN.
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus ();

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MTHI, K_MTLO} kind_t;
    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] hi_m, lo_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #2;
    endtask

    task automatic idle_inputs();
        bus.mult = 0; bus.multu = 0; bus.div = 0; bus.divu = 0;
        bus.mthi = 0; bus.mtlo = 0; bus.mfhi = 0; bus.mflo = 0;
        bus.issue = 0; bus.a = '0; bus.b = '0;
    endtask

    task automatic drive_req(input kind_t k, input logic [31:0] a, input logic [31:0] b);
        idle_inputs();
        bus.issue = 1;
        bus.a = a;
        bus.b = b;
        case (k)
            K_MULT:  bus.mult  = 1;
            K_MULTU: bus.multu = 1;
            K_DIV:   bus.div   = 1;
            K_DIVU:  bus.divu  = 1;
            K_MTHI:  bus.mthi  = 1;
            K_MTLO:  bus.mtlo  = 1;
            default: ;
        endcase
    endtask

    // Issues in the current cycle N and follows the op to completion in N+33.
    task automatic run_muldiv(input string tag, input kind_t k, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh,
                              input logic [31:0] el, input bit with_mthi);
        exp_t e;
        int   lat = 0;
        int   nbusy = 0;
        bit   got = 0;
        bit   held = 1;
        drive_req(k, a, b);
        if (with_mthi) bus.mthi = 1;
        sample();
        check({tag, " accept_stall"}, 32'(bus.stall), 32'd1);
        sb.push_back('{tag, eh, el});
        for (int i = 1; i <= 40 && !got; i++) begin
            next_cycle();
            if (i == 1) idle_inputs();
            sample();
            if (bus.done) begin
                got = 1;
                lat = i;
            end else begin
                if (bus.busy) nbusy++;
                if (bus.hi !== hi_m || bus.lo !== lo_m) held = 0;
            end
        end
        check({tag, " latency"}, lat, 33);
        check({tag, " busy_cycles"}, nbusy, 32);
        check({tag, " hilo_held"}, 32'(held), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, " hi"}, bus.hi, e.hi);
            check({e.tag, " lo"}, bus.lo, e.lo);
            check({e.tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
            hi_m = e.hi;
            lo_m = e.lo;
        end
    endtask

    task automatic run_mt(input string tag, input kind_t k, input logic [31:0] a);
        drive_req(k, a, '0);
        sample();
        check({tag, " accept_stall"}, 32'(bus.stall), 32'd1);
        next_cycle();
        idle_inputs();
        sample();
        if (k == K_MTHI) hi_m = a;
        else             lo_m = a;
        check({tag, " hi"}, bus.hi, hi_m);
        check({tag, " lo"}, bus.lo, lo_m);
    endtask

`ifndef MULDIV_DIV_EN
    task automatic run_noop(input string tag, input kind_t k, input logic [31:0] a,
                            input logic [31:0] b);
        bit seen = 0;
        drive_req(k, a, b);
        sample();
        check({tag, " accept_stall"}, 32'(bus.stall), 32'd1);
        for (int i = 1; i <= 36; i++) begin
            next_cycle();
            if (i == 1) idle_inputs();
            sample();
            if (bus.busy || bus.done) seen = 1;
        end
        check({tag, " no_busy_done"}, 32'(seen), 32'd0);
        check({tag, " hi"}, bus.hi, hi_m);
        check({tag, " lo"}, bus.lo, lo_m);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   nstall;
        bit   seen;

        idle_inputs();
        rst_n = 0;
        hi_m  = '0;
        lo_m  = '0;
        repeat (2) next_cycle();
        rst_n = 1;
        sample();
        check("reset hi", bus.hi, 32'h0);
        check("reset lo", bus.lo, 32'h0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        check("reset stall", 32'(bus.stall), 32'd1);

        // Strobes without issue: nothing happens.
        next_cycle();
        bus.mult = 1; bus.mthi = 1; bus.a = 32'h55; bus.b = 32'h3; bus.issue = 0;
        sample();
        check("noissue stall", 32'(bus.stall), 32'd1);
        next_cycle();
        idle_inputs();
        sample();
        check("noissue busy", 32'(bus.busy), 32'd0);
        check("noissue hi", bus.hi, hi_m);

        next_cycle();
        run_mt("mthi", K_MTHI, 32'hA5A5_0001);
        next_cycle();
        run_mt("mtlo", K_MTLO, 32'h0F0F_7777);

        next_cycle();
        run_muldiv("mult_neg3x7", K_MULT, 32'hFFFF_FFFD, 32'd7,
                   32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
        // Back-to-back: next ops issue in the done cycle.
        run_muldiv("multu_max", K_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_muldiv("mult_minmin", K_MULT, 32'h8000_0000, 32'h8000_0000,
                   32'h4000_0000, 32'h0000_0000, 0);
        run_muldiv("prio_mult_mthi", K_MULT, 32'd3, 32'd5,
                   32'h0000_0000, 32'h0000_000F, 1);

`ifdef MULDIV_DIV_EN
        run_muldiv("div_neg7_2", K_DIV, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_muldiv("divu_100_7", K_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_muldiv("divu_5_0", K_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
        run_muldiv("div_neg5_0", K_DIV, 32'hFFFF_FFFB, 32'd0,
                   32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
        run_muldiv("div_ovf", K_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'h0000_0000, 32'h8000_0000, 0);
        run_muldiv("div_7_neg2", K_DIV, 32'd7, 32'hFFFF_FFFE,
                   32'h0000_0001, 32'hFFFF_FFFD, 0);
`else
        run_noop("div_noop", K_DIV, 32'hFFFF_FFF9, 32'd2);
        next_cycle();
        run_noop("divu_noop", K_DIVU, 32'd100, 32'd7);
`endif

        // mflo held from N+5 stalls until the result is visible in N+33.
        next_cycle();
        drive_req(K_MULT, 32'h0000_1234, 32'hFFFF_FFFE);
        sample();
        check("mflo_run accept_stall", 32'(bus.stall), 32'd1);
        sb.push_back('{"mflo_run", 32'hFFFF_FFFF, 32'hFFFF_DB98});
        nstall = 0;
        for (int i = 1; i <= 33; i++) begin
            next_cycle();
            idle_inputs();
            if (i == 2) begin
                bus.issue = 1; bus.mthi = 1; bus.a = 32'hDEAD_BEEF;
            end
            if (i >= 5) bus.mflo = 1;
            if (i == 33) begin
                bus.issue = 1; bus.mtlo = 1; bus.a = 32'h0000_1234;
            end
            sample();
            if (i == 2) check("run_mthi stall", 32'(bus.stall), 32'd0);
            if (i == 3) check("run_mthi ignored", bus.hi, hi_m);
            if (i >= 5 && i <= 32 && bus.stall == 1'b0) nstall++;
        end
        check("mflo stall_cycles", nstall, 28);
        check("mflo stall_at_done", 32'(bus.stall), 32'd1);
        check("mflo done", 32'(bus.done), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, " hi"}, bus.hi, e.hi);
            check({e.tag, " lo"}, bus.lo, e.lo);
            hi_m = e.hi;
            lo_m = e.lo;
        end
        next_cycle();
        idle_inputs();
        sample();
        lo_m = 32'h0000_1234;
        check("mtlo_after lo", bus.lo, lo_m);
        check("mtlo_after hi", bus.hi, hi_m);

        // Reset in N+10 of an iterative op discards it.
        next_cycle();
`ifdef MULDIV_DIV_EN
        drive_req(K_DIV, 32'd1000, 32'd3);
`else
        drive_req(K_MULT, 32'd1000, 32'd3);
`endif
        sample();
        for (int i = 1; i <= 10; i++) begin
            next_cycle();
            if (i == 1) idle_inputs();
            if (i == 10) rst_n = 0;
            sample();
        end
        check("rst_mid busy_before", 32'(bus.busy), 32'd1);
        next_cycle();
        rst_n = 1;
        sample();
        hi_m = '0;
        lo_m = '0;
        check("rst_mid busy", 32'(bus.busy), 32'd0);
        check("rst_mid hi", bus.hi, hi_m);
        check("rst_mid lo", bus.lo, lo_m);
        seen = bus.done;
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            sample();
            if (bus.done) seen = 1;
        end
        check("rst_mid no_done", 32'(seen), 32'd0);
        check("rst_mid hi_later", bus.hi, hi_m);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
